iter_shifter: RTL and testbench



---
 rtl/iter_shifter_pkg.sv | 20 ++
 rtl/iter_shifter_if.sv | 25 ++
 rtl/iter_shifter_step.sv | 34 +++
 rtl/iter_shifter.sv | 116 +++++++++++
 tb/tb_iter_shifter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter: op encodings, FSM states and
// the default operand width.
package shift_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle between the ALU control FSM (master) and the
// iterative shifter (slave).
interface iter_shifter_if #(
    parameter int WIDTH = shift_pkg::WIDTH_DEF
) ();

    logic                     start;
    shift_pkg::op_e           op;
    logic [WIDTH-1:0]         num;
    logic [$clog2(WIDTH)-1:0] shamt;
    logic                     busy;
    logic                     done;
    logic [WIDTH-1:0]         result;

    modport master (
        output start, op, num, shamt,
        input  busy, done, result
    );

    modport slave (
        input  start, op, num, shamt,
        output busy, done, result
    );

endinterface

// File: rtl/iter_shifter_step.sv
// One combinational step of the shifter: moves din by 0..STEP positions.
// fill supplies the bit shifted into the vacated MSBs on right shifts.
// The rotate path exists only when SHIFTER_ROTATE_EN is defined.
module shift_step
    import shift_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int STEP  = 1,
    localparam int AMT_W = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    input  op_e              op,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] vac_hi;

    // Select the shifted value for the current op; vac_hi marks vacated MSBs.
    always_comb begin
        vac_hi = ~({WIDTH{1'b1}} >> amt);
        dout   = din;
        case (op)
            OP_SLL:         dout = din << amt;
            OP_SRL, OP_SRA: dout = (din >> amt) | ({WIDTH{fill}} & vac_hi);
`ifdef SHIFTER_ROTATE_EN
            OP_ROR:         dout = (din >> amt) | (din << (WIDTH - int'(amt)));
`endif
            default:        dout = din;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA (and ROR with SHIFTER_ROTATE_EN) by a
// runtime amount, at most STEP positions per clock, start/busy/done handshake.
// Optional feature macro: SHIFTER_ROTATE_EN.
//
// SHIFT holds one extra "drain" cycle once rem hits zero (busy already low)
// before entering DONE; a zero-length request takes only this drain cycle.
// This gives accept-to-done latency of ceil(shamt/STEP)+1 edges and keeps
// result stable for the whole DONE cycle.
module iter_shifter
    import shift_pkg::*;
#(
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    iter_shifter_if.slave bus
);

    localparam int                 AMT_W  = $clog2(STEP) + 1;
    localparam logic [SHAMT_W:0]   STEP_X = (SHAMT_W + 1)'(STEP);
    localparam logic [AMT_W-1:0]   STEP_A = AMT_W'(STEP);

    state_e             state, state_d;
    logic [SHAMT_W-1:0] rem;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   step_out;
    op_e                op_q;
    logic               sign_q;
    logic               accept;
    logic [AMT_W-1:0]   s;
    logic [SHAMT_W:0]   rem_x;
    logic               fill;
    logic [SHAMT_W-1:0] shamt_eff;

    // Per-cycle step size min(STEP, rem) and right-shift fill bit.
    always_comb begin
        rem_x = {1'b0, rem};
        s     = (rem_x >= STEP_X) ? STEP_A : rem_x[AMT_W-1:0];
        fill  = (op_q == OP_SRA) & sign_q;
    end

    // Without the rotate datapath, ROR degenerates to a zero-length shift.
    always_comb begin
`ifdef SHIFTER_ROTATE_EN
        shamt_eff = bus.shamt;
`else
        shamt_eff = (bus.op == OP_ROR) ? '0 : bus.shamt;
`endif
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .din  (work),
        .amt  (s),
        .op   (op_q),
        .fill (fill),
        .dout (step_out)
    );

    // Next-state logic and request acceptance.
    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, remaining count and working register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rem    <= '0;
            work   <= '0;
            op_q   <= OP_SLL;
            sign_q <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                work   <= bus.num;
                rem    <= shamt_eff;
                op_q   <= bus.op;
                sign_q <= bus.num[WIDTH-1];
            end else if (state == ST_SHIFT && rem != '0) begin
                work <= step_out;
                rem  <= rem - SHAMT_W'(s);
            end
        end
    end

    assign bus.busy   = (state == ST_SHIFT) && (rem != '0);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = work;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: three instances with STEP = 1, 2, 4
// sharing clk/rst, driven with hand-computed vectors.
module tb_iter_shifter;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iter_shifter_if #(.WIDTH(32)) b1 ();
    iter_shifter_if #(.WIDTH(32)) b2 ();
    iter_shifter_if #(.WIDTH(32)) b4 ();

    iter_shifter #(.WIDTH(32), .STEP(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    iter_shifter #(.WIDTH(32), .STEP(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    iter_shifter #(.WIDTH(32), .STEP(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    // index 0 -> STEP 1, 1 -> STEP 2, 2 -> STEP 4
    logic        start_v [3];
    op_e         op_v    [3];
    logic [31:0] num_v   [3];
    logic [4:0]  shamt_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [31:0] res_v   [3];

    assign b1.start = start_v[0]; assign b1.op = op_v[0]; assign b1.num = num_v[0]; assign b1.shamt = shamt_v[0];
    assign b2.start = start_v[1]; assign b2.op = op_v[1]; assign b2.num = num_v[1]; assign b2.shamt = shamt_v[1];
    assign b4.start = start_v[2]; assign b4.op = op_v[2]; assign b4.num = num_v[2]; assign b4.shamt = shamt_v[2];
    assign busy_v[0] = b1.busy; assign done_v[0] = b1.done; assign res_v[0] = b1.result;
    assign busy_v[1] = b2.busy; assign done_v[1] = b2.done; assign res_v[1] = b2.result;
    assign busy_v[2] = b4.busy; assign done_v[2] = b4.done; assign res_v[2] = b4.result;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance i and wait for done (bounded).
    // b0: busy right after the accept edge; bcnt: cycles busy was seen;
    // dedge: edge index (accept = 0) at which done was first seen, -1 on timeout.
    task automatic run(input int i, input op_e op, input logic [31:0] num,
                       input logic [4:0] sh, input bit nowait,
                       output logic b0, output int bcnt, output int dedge,
                       output logic [31:0] res);
        if (!nowait) @(negedge clk);
        start_v[i] = 1'b1; op_v[i] = op; num_v[i] = num; shamt_v[i] = sh;
        @(posedge clk); #1;
        start_v[i] = 1'b0;
        b0    = busy_v[i];
        bcnt  = b0 ? 1 : 0;
        dedge = -1;
        res   = '0;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk); #1;
            if (done_v[i]) begin
                dedge = e;
                res   = res_v[i];
                break;
            end
            if (busy_v[i]) bcnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        b0;
        int          bcnt, dedge;
        logic [31:0] res;
        logic        seen;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; op_v[i] = OP_SLL; num_v[i] = '0; shamt_v[i] = '0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy",   32'(busy_v[i]), 32'd0);
            chk("rst_done",   32'(done_v[i]), 32'd0);
            chk("rst_result", res_v[i],       32'd0);
        end
        @(negedge clk) rst = 1'b0;

        // STEP1 SLL 1 by 31: longest shift
        run(0, OP_SLL, 32'h0000_0001, 5'd31, 1'b0, b0, bcnt, dedge, res);
        chk("sll31_busycnt", 32'(bcnt),  32'd31);
        chk("sll31_edge",    32'(dedge), 32'd32);
        chk("sll31_res",     res,        32'h8000_0000);
        @(posedge clk); #1;
        chk("sll31_pulse",   32'(done_v[0]), 32'd0);

        // STEP4 SRA 0x800000F0 by 6: full step then partial step
        run(2, OP_SRA, 32'h8000_00F0, 5'd6, 1'b0, b0, bcnt, dedge, res);
        chk("sra6_busycnt", 32'(bcnt),  32'd2);
        chk("sra6_edge",    32'(dedge), 32'd3);
        chk("sra6_res",     res,        32'hFE00_0003);

        // STEP1 SRL by 0: no busy, done after one edge
        run(0, OP_SRL, 32'hFFFF_FFFF, 5'd0, 1'b0, b0, bcnt, dedge, res);
        chk("sh0_busycnt", 32'(bcnt),  32'd0);
        chk("sh0_edge",    32'(dedge), 32'd1);
        chk("sh0_res",     res,        32'hFFFF_FFFF);

        // STEP4 SRA of negative by 31 -> all ones, N = 8
        run(2, OP_SRA, 32'h8000_0000, 5'd31, 1'b0, b0, bcnt, dedge, res);
        chk("sra31_edge", 32'(dedge), 32'd9);
        chk("sra31_res",  res,        32'hFFFF_FFFF);

        // STEP4 SRL by 31 of same operand -> single bit, zero fill
        run(2, OP_SRL, 32'h8000_0000, 5'd31, 1'b0, b0, bcnt, dedge, res);
        chk("srl31_res",  res,        32'h0000_0001);

        // STEP2 SLL 0xFF by 5: steps 2,2,1
        run(1, OP_SLL, 32'h0000_00FF, 5'd5, 1'b0, b0, bcnt, dedge, res);
        chk("sll5_edge", 32'(dedge), 32'd4);
        chk("sll5_res",  res,        32'h0000_1FE0);

        // STEP2 back-to-back: second start issued in the done cycle
        run(1, OP_SLL, 32'h0000_0001, 5'd3, 1'b0, b0, bcnt, dedge, res);
        chk("b2b1_edge", 32'(dedge), 32'd3);
        chk("b2b1_res",  res,        32'h0000_0008);
        run(1, OP_SRL, 32'h0000_0008, 5'd1, 1'b1, b0, bcnt, dedge, res);
        chk("b2b2_busy0", 32'(b0),    32'd1);
        chk("b2b2_edge",  32'(dedge), 32'd2);
        chk("b2b2_res",   res,        32'h0000_0004);
        @(posedge clk); #1;

        // STEP1 SRL by 20, start ignored mid-shift, reset aborts
        @(negedge clk);
        start_v[0] = 1'b1; op_v[0] = OP_SRL; num_v[0] = 32'hABCD_1234; shamt_v[0] = 5'd20;
        @(posedge clk); #1;                 // edge 0
        start_v[0] = 1'b0;
        @(posedge clk); #1;                 // edge 1
        @(posedge clk); #1;                 // edge 2
        start_v[0] = 1'b1; op_v[0] = OP_SLL; num_v[0] = 32'h0; shamt_v[0] = 5'd1;
        @(posedge clk); #1;                 // edge 3
        start_v[0] = 1'b0;
        chk("mid_busy", 32'(busy_v[0]), 32'd1);
        chk("mid_res",  res_v[0],       32'h1579_A246);
        @(posedge clk); #1;                 // edge 4
        rst = 1'b1;
        @(posedge clk); #1;                 // edge 5
        chk("abort_busy", 32'(busy_v[0]), 32'd0);
        chk("abort_done", 32'(done_v[0]), 32'd0);
        chk("abort_res",  res_v[0],       32'd0);
        rst  = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            seen = seen | done_v[0] | busy_v[0];
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        // STEP4 ROR 0x12345678 by 8
        run(2, OP_ROR, 32'h1234_5678, 5'd8, 1'b0, b0, bcnt, dedge, res);
`ifdef SHIFTER_ROTATE_EN
        chk("ror_edge", 32'(dedge), 32'd3);
        chk("ror_res",  res,        32'h7812_3456);
`else
        chk("ror_edge", 32'(dedge), 32'd1);
        chk("ror_res",  res,        32'h1234_5678);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
